timing_reg_sched: RTL and testbench

- Arbitrates two requesters that write one shared 11-bit timing register (an 11-bit enabled register bank: D, CLK, ENA, Q) in the MPPT CPLD.
- Requester A is the microcontroller host-write path; requester B is the soft-start ramp generator.
- Each winning value is clamped, then committed only on a PWM period boundary (SYNC) so the PWM timing never changes mid-period.
- A timeout forces the commit if SYNC stalls.

---
 rtl/timing_reg_sched.sv | 119 +++++++++++
 tb/tb_timing_reg_sched.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/timing_reg_sched.sv
// Arbitrates host (A) and soft-start ramp (B) writes to the shared 11-bit PWM timing register.
// Values are clamped and committed only on a PWM period boundary, with a timeout fallback.
module timing_reg_sched #(
    parameter logic [10:0] MAX_VAL = 11'd2000,
    parameter logic [7:0]  TIMEOUT = 8'd200
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_a_i,
    input  logic [10:0] data_a_i,
    output logic        ack_a_o,
    input  logic        req_b_i,
    input  logic [10:0] data_b_i,
    output logic        ack_b_o,
    input  logic        sync_i,
    output logic [10:0] reg_d_o,
    output logic        reg_ena_o,
    output logic        busy_o,
    output logic        clamped_o,
    output logic        tmo_err_o
);

    typedef enum logic [1:0] {StIdle, StWait, StCommit, StAck} state_e;

    localparam logic SrcA = 1'b0;
    localparam logic SrcB = 1'b1;

    state_e      state_q, state_d;
    logic        src_q, src_d;
    logic        last_q, last_d;
    logic [10:0] reg_d_q, reg_d_d;
    logic        clamp_q, clamp_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        tmo_q, tmo_d;

    logic        grant;
    logic        grant_src;
    logic [10:0] grant_data;

    // Round-robin: on a tie the source that did not win last time is granted.
    always_comb begin
        grant      = req_a_i | req_b_i;
        grant_src  = req_b_i & (~req_a_i | (last_q == SrcA));
        grant_data = (grant_src == SrcB) ? data_b_i : data_a_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            src_q   <= SrcA;
            last_q  <= SrcB;
            reg_d_q <= 11'd0;
            clamp_q <= 1'b0;
            cnt_q   <= 8'd0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            last_q  <= last_d;
            reg_d_q <= reg_d_d;
            clamp_q <= clamp_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        last_d  = last_q;
        reg_d_d = reg_d_q;
        clamp_d = clamp_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        unique case (state_q)
            StIdle: begin
                if (grant) begin
                    src_d   = grant_src;
                    clamp_d = (grant_data > MAX_VAL);
                    reg_d_d = (grant_data > MAX_VAL) ? MAX_VAL : grant_data;
                    cnt_d   = 8'd0;
                    state_d = StWait;
                end
            end
            StWait: begin
                // A SYNC on the timeout cycle is a normal commit, not a forced one.
                if (sync_i) begin
                    state_d = StCommit;
                end else if (cnt_q == TIMEOUT - 8'd1) begin
                    tmo_d   = 1'b1;
                    state_d = StCommit;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StCommit: begin
                state_d = StAck;
            end
            StAck: begin
                last_d  = src_q;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        reg_d_o   = reg_d_q;
        reg_ena_o = (state_q == StCommit);
        busy_o    = (state_q != StIdle);
        ack_a_o   = (state_q == StAck) & (src_q == SrcA);
        ack_b_o   = (state_q == StAck) & (src_q == SrcB);
        clamped_o = (state_q == StAck) & clamp_q;
        tmo_err_o = tmo_q;
    end

endmodule

// File: tb/tb_timing_reg_sched.sv
// Directed vector bench for timing_reg_sched: table of per-cycle stimulus/expectations plus
// hand-written timeout sequences.
module tb_timing_reg_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_a = 1'b0;
    logic [10:0] data_a = 11'd0;
    logic        req_b = 1'b0;
    logic [10:0] data_b = 11'd0;
    logic        sync = 1'b0;
    logic        ack_a, ack_b, reg_ena, busy, clamped, tmo_err;
    logic [10:0] reg_d;

    int n_vec = 0;
    int n_err = 0;

    timing_reg_sched dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .req_a_i  (req_a),
        .data_a_i (data_a),
        .ack_a_o  (ack_a),
        .req_b_i  (req_b),
        .data_b_i (data_b),
        .ack_b_o  (ack_b),
        .sync_i   (sync),
        .reg_d_o  (reg_d),
        .reg_ena_o(reg_ena),
        .busy_o   (busy),
        .clamped_o(clamped),
        .tmo_err_o(tmo_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ra;
        logic [10:0] da;
        logic        rb;
        logic [10:0] db;
        logic        sy;
        logic        aa;
        logic        ab;
        logic        en;
        logic [10:0] rd;
        logic        bz;
        logic        cl;
        logic        te;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int r, int ra, int da, int rb, int db, int sy,
                                int aa, int ab, int en, int rd, int bz, int cl, int te);
        vec_t v;
        v.rst = r[0];  v.ra = ra[0]; v.da = 11'(da); v.rb = rb[0]; v.db = 11'(db);
        v.sy  = sy[0]; v.aa = aa[0]; v.ab = ab[0];   v.en = en[0]; v.rd = 11'(rd);
        v.bz  = bz[0]; v.cl = cl[0]; v.te = te[0];
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        // rst ra da rb db sy | ack_a ack_b ena reg_d busy clamped tmo
        vecs.push_back(mk(1, 0,   0, 0,    0, 0,  0, 0, 0,    0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 500, 0,    0, 0,  0, 0, 0,  500, 1, 0, 0));
        vecs.push_back(mk(0, 1, 500, 0,    0, 0,  0, 0, 0,  500, 1, 0, 0));
        vecs.push_back(mk(0, 1, 500, 0,    0, 0,  0, 0, 0,  500, 1, 0, 0));
        vecs.push_back(mk(0, 1, 500, 0,    0, 0,  0, 0, 0,  500, 1, 0, 0));
        vecs.push_back(mk(0, 1, 500, 0,    0, 1,  0, 0, 1,  500, 1, 0, 0));
        vecs.push_back(mk(0, 1, 500, 0,    0, 0,  1, 0, 0,  500, 1, 0, 0));
        vecs.push_back(mk(0, 0,   0, 0,    0, 0,  0, 0, 0,  500, 0, 0, 0));
        // Both held: A, B, A
        vecs.push_back(mk(1, 1, 100, 1,  200, 0,  0, 0, 0,    0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 100, 1,  200, 0,  0, 0, 0,  100, 1, 0, 0));
        vecs.push_back(mk(0, 1, 100, 1,  200, 1,  0, 0, 1,  100, 1, 0, 0));
        vecs.push_back(mk(0, 1, 100, 1,  200, 0,  1, 0, 0,  100, 1, 0, 0));
        vecs.push_back(mk(0, 1, 100, 1,  200, 0,  0, 0, 0,  100, 0, 0, 0));
        vecs.push_back(mk(0, 1, 100, 1,  200, 0,  0, 0, 0,  200, 1, 0, 0));
        vecs.push_back(mk(0, 1, 100, 1,  200, 1,  0, 0, 1,  200, 1, 0, 0));
        vecs.push_back(mk(0, 1, 100, 1,  200, 0,  0, 1, 0,  200, 1, 0, 0));
        vecs.push_back(mk(0, 1, 100, 1,  200, 0,  0, 0, 0,  200, 0, 0, 0));
        vecs.push_back(mk(0, 1, 100, 1,  200, 0,  0, 0, 0,  100, 1, 0, 0));
        vecs.push_back(mk(0, 1, 100, 1,  200, 1,  0, 0, 1,  100, 1, 0, 0));
        vecs.push_back(mk(0, 1, 100, 1,  200, 0,  1, 0, 0,  100, 1, 0, 0));
        // Clamp on B
        vecs.push_back(mk(0, 0,   0, 0,    0, 0,  0, 0, 0,  100, 0, 0, 0));
        vecs.push_back(mk(0, 0,   0, 1, 2047, 0,  0, 0, 0, 2000, 1, 0, 0));
        vecs.push_back(mk(0, 0,   0, 1, 2047, 1,  0, 0, 1, 2000, 1, 0, 0));
        vecs.push_back(mk(0, 0,   0, 1, 2047, 0,  0, 1, 0, 2000, 1, 1, 0));
        vecs.push_back(mk(0, 0,   0, 0,    0, 0,  0, 0, 0, 2000, 0, 0, 0));
        // SYNC in grant cycle ignored
        vecs.push_back(mk(0, 1, 300, 0,    0, 1,  0, 0, 0,  300, 1, 0, 0));
        vecs.push_back(mk(0, 1, 300, 0,    0, 0,  0, 0, 0,  300, 1, 0, 0));
        vecs.push_back(mk(0, 1, 300, 0,    0, 1,  0, 0, 1,  300, 1, 0, 0));
        vecs.push_back(mk(0, 1, 300, 0,    0, 0,  1, 0, 0,  300, 1, 0, 0));
        vecs.push_back(mk(0, 0,   0, 0,    0, 0,  0, 0, 0,  300, 0, 0, 0));
        // SYNC in IDLE not queued
        vecs.push_back(mk(0, 0,   0, 0,    0, 1,  0, 0, 0,  300, 0, 0, 0));
        vecs.push_back(mk(0, 1,   7, 0,    0, 0,  0, 0, 0,    7, 1, 0, 0));
        vecs.push_back(mk(0, 1,   7, 0,    0, 0,  0, 0, 0,    7, 1, 0, 0));
        vecs.push_back(mk(0, 1,   7, 0,    0, 1,  0, 0, 1,    7, 1, 0, 0));
        vecs.push_back(mk(0, 1,   7, 0,    0, 0,  1, 0, 0,    7, 1, 0, 0));
        vecs.push_back(mk(0, 0,   0, 0,    0, 0,  0, 0, 0,    7, 0, 0, 0));
        // Reset in WAIT drops the request; held REQ_A re-granted
        vecs.push_back(mk(0, 1,  42, 0,    0, 0,  0, 0, 0,   42, 1, 0, 0));
        vecs.push_back(mk(1, 1,  42, 0,    0, 0,  0, 0, 0,    0, 0, 0, 0));
        vecs.push_back(mk(0, 1,  42, 0,    0, 0,  0, 0, 0,   42, 1, 0, 0));
        vecs.push_back(mk(0, 1,  42, 0,    0, 1,  0, 0, 1,   42, 1, 0, 0));
        vecs.push_back(mk(0, 1,  42, 0,    0, 0,  1, 0, 0,   42, 1, 0, 0));
        vecs.push_back(mk(0, 0,   0, 0,    0, 0,  0, 0, 0,   42, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; req_a = vecs[i].ra; data_a = vecs[i].da;
            req_b = vecs[i].rb; data_b = vecs[i].db; sync = vecs[i].sy;
            tick();
            n_vec++;
            if ({ack_a, ack_b, reg_ena, reg_d, busy, clamped, tmo_err} !==
                {vecs[i].aa, vecs[i].ab, vecs[i].en, vecs[i].rd, vecs[i].bz, vecs[i].cl,
                 vecs[i].te}) begin
                n_err++;
                $display("FAIL vec%0d: got ack_a=%b ack_b=%b ena=%b reg_d=%0d busy=%b clamp=%b tmo=%b, expected ack_a=%b ack_b=%b ena=%b reg_d=%0d busy=%b clamp=%b tmo=%b",
                         i, ack_a, ack_b, reg_ena, reg_d, busy, clamped, tmo_err,
                         vecs[i].aa, vecs[i].ab, vecs[i].en, vecs[i].rd, vecs[i].bz,
                         vecs[i].cl, vecs[i].te);
            end
        end

        // Forced commit after 200 WAIT cycles without SYNC
        begin
            int first_ena;
            first_ena = -1;
            rst = 1'b1; tick(); rst = 1'b0;
            req_a = 1'b1; data_a = 11'd1000; sync = 1'b0;
            tick();
            chk("tmo_grant_reg_d", 32'(reg_d), 32'd1000);
            for (int i = 1; i <= 300; i++) begin
                tick();
                if (reg_ena === 1'b1) begin
                    first_ena = i;
                    break;
                end
            end
            chk("tmo_ena_cycle", 32'(first_ena), 32'd200);
            chk("tmo_err_set", 32'(tmo_err), 32'd1);
            tick();
            chk("tmo_ack_a", 32'(ack_a), 32'd1);
            req_a = 1'b0;
            tick();
            req_b = 1'b1; data_b = 11'd50;
            tick();
            sync = 1'b1; tick(); sync = 1'b0;
            chk("norm_ena", 32'(reg_ena), 32'd1);
            tick();
            chk("norm_ack_b", 32'(ack_b), 32'd1);
            chk("tmo_err_sticky", 32'(tmo_err), 32'd1);
            req_b = 1'b0;
            tick();
            rst = 1'b1; tick(); rst = 1'b0;
            chk("tmo_err_cleared", 32'(tmo_err), 32'd0);
        end

        // SYNC arriving on the timeout cycle is a normal commit
        req_a = 1'b1; data_a = 11'd600;
        tick();
        repeat (199) tick();
        chk("edge_no_early_ena", 32'(reg_ena), 32'd0);
        sync = 1'b1; tick(); sync = 1'b0;
        chk("edge_ena", 32'(reg_ena), 32'd1);
        chk("edge_tmo_err", 32'(tmo_err), 32'd0);
        tick();
        chk("edge_ack_a", 32'(ack_a), 32'd1);
        req_a = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
